// File: rtl/comet_ii_pkg.sv
// Shared COMET II definitions: word width, sequencer state encodings and opcode constants.
package comet_ii_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_INIT  = 3'b001,
        ST_IFET1 = 3'b010,
        ST_IFET2 = 3'b011,
        ST_EXEC  = 3'b100,
        ST_WBACK = 3'b101
    } state_t;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LD     = 8'h10;
    localparam logic [7:0] OP_ST     = 8'h11;
    localparam logic [7:0] OP_LAD    = 8'h12;
    localparam logic [7:0] OP_LD_R   = 8'h14;
    localparam logic [7:0] OP_ADDA   = 8'h20;
    localparam logic [7:0] OP_SUBA   = 8'h21;
    localparam logic [7:0] OP_ADDL   = 8'h22;
    localparam logic [7:0] OP_SUBL   = 8'h23;
    localparam logic [7:0] OP_ADDA_R = 8'h24;
    localparam logic [7:0] OP_SUBA_R = 8'h25;
    localparam logic [7:0] OP_ADDL_R = 8'h26;
    localparam logic [7:0] OP_SUBL_R = 8'h27;
    localparam logic [7:0] OP_AND    = 8'h30;
    localparam logic [7:0] OP_OR     = 8'h31;
    localparam logic [7:0] OP_XOR    = 8'h32;
    localparam logic [7:0] OP_AND_R  = 8'h34;
    localparam logic [7:0] OP_OR_R   = 8'h35;
    localparam logic [7:0] OP_XOR_R  = 8'h36;
    localparam logic [7:0] OP_CPA    = 8'h40;
    localparam logic [7:0] OP_CPL    = 8'h41;
    localparam logic [7:0] OP_CPA_R  = 8'h44;
    localparam logic [7:0] OP_CPL_R  = 8'h45;
    localparam logic [7:0] OP_SLA    = 8'h50;
    localparam logic [7:0] OP_SRA    = 8'h51;
    localparam logic [7:0] OP_SLL    = 8'h52;
    localparam logic [7:0] OP_SRL    = 8'h53;
    localparam logic [7:0] OP_JMI    = 8'h61;
    localparam logic [7:0] OP_JNZ    = 8'h62;
    localparam logic [7:0] OP_JZE    = 8'h63;
    localparam logic [7:0] OP_JUMP   = 8'h64;
    localparam logic [7:0] OP_JPL    = 8'h65;
    localparam logic [7:0] OP_JOV    = 8'h66;
    localparam logic [7:0] OP_PUSH   = 8'h70;
    localparam logic [7:0] OP_POP    = 8'h71;
    localparam logic [7:0] OP_CALL   = 8'h80;
    localparam logic [7:0] OP_RET    = 8'h81;
    localparam logic [7:0] OP_SVC    = 8'hF0;

endpackage

// File: rtl/comet_ii_op_length.sv
// Combinational opcode classifier: does the instruction carry an address word, and is it a known opcode.
module comet_ii_op_length
    import comet_ii_pkg::*;
(
    input  logic [7:0] op_code,
    output logic       two_word,
    output logic       legal
);

    always_comb begin
        two_word = 1'b0;
        legal    = 1'b1;
        case (op_code)
            OP_LD, OP_ST, OP_LAD,
            OP_ADDA, OP_SUBA, OP_ADDL, OP_SUBL,
            OP_AND, OP_OR, OP_XOR,
            OP_CPA, OP_CPL,
            OP_SLA, OP_SRA, OP_SLL, OP_SRL,
            OP_JMI, OP_JNZ, OP_JZE, OP_JUMP, OP_JPL, OP_JOV,
            OP_PUSH, OP_CALL, OP_SVC:
                two_word = 1'b1;
            OP_NOP, OP_LD_R,
            OP_ADDA_R, OP_SUBA_R, OP_ADDL_R, OP_SUBL_R,
            OP_AND_R, OP_OR_R, OP_XOR_R,
            OP_CPA_R, OP_CPL_R,
            OP_POP, OP_RET:
                two_word = 1'b0;
            default:
                legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/comet_ii_fetch_sequencer.sv
// COMET II fetch/state sequencer: owns PR, fetches 1-2 word instructions, drives decoder state.
// Optional feature: define COMET_II_ILLEGAL_TRAP_EN to trap unknown opcodes back to IDLE.
module comet_ii_fetch_sequencer
    import comet_ii_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              start_addr_sel,
    input  logic [WORD_W-1:0] start_addr,
    input  logic              stop,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              exec_done,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    output logic [2:0]        state,
    output logic [7:0]        op_code,
    output logic [7:0]        regs,
    output logic [WORD_W-1:0] adr,
    output logic              adr_en,
    output logic [WORD_W-1:0] pr,
    output logic              illegal
);

    state_t            state_q;
    logic [WORD_W-1:0] pr_q;
    logic [WORD_W-1:0] pr_inc;
    logic              two_word;
    logic              legal;
    logic              needs_adr;
    logic              fetch_ack;

    comet_ii_op_length u_op_length (
        .op_code  (mem_rdata[15:8]),
        .two_word (two_word),
        .legal    (legal)
    );

    // Only recognised two-word opcodes fetch an address word; unknown ones run as one-word.
    assign needs_adr = two_word & legal;
    assign pr_inc    = pr_q + 16'd1;
    assign fetch_ack = mem_req & mem_ack;

    assign state    = state_q;
    assign pr       = pr_q;
    assign mem_addr = pr_q;

`ifdef COMET_II_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pr_q    <= '0;
            op_code <= '0;
            regs    <= '0;
            adr     <= '0;
            adr_en  <= 1'b0;
            mem_req <= 1'b0;
`ifdef COMET_II_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mem_req <= 1'b0;
                    if (start) state_q <= ST_INIT;
                end
                ST_INIT: begin
                    pr_q    <= start_addr_sel ? start_addr : RESET_PR;
                    adr_en  <= 1'b0;
                    mem_req <= 1'b1;
                    state_q <= ST_IFET1;
`ifdef COMET_II_ILLEGAL_TRAP_EN
                    illegal_q <= 1'b0;
`endif
                end
                ST_IFET1: begin
                    if (fetch_ack) begin
                        op_code <= mem_rdata[15:8];
                        regs    <= mem_rdata[7:0];
                        pr_q    <= pr_inc;
`ifdef COMET_II_ILLEGAL_TRAP_EN
                        if (!legal) begin
                            illegal_q <= 1'b1;
                            mem_req   <= 1'b0;
                            state_q   <= ST_IDLE;
                        end else
`endif
                        if (needs_adr) begin
                            state_q <= ST_IFET2;
                        end else begin
                            adr     <= '0;
                            adr_en  <= 1'b0;
                            mem_req <= 1'b0;
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_IFET2: begin
                    if (fetch_ack) begin
                        adr     <= mem_rdata;
                        adr_en  <= 1'b1;
                        pr_q    <= pr_inc;
                        mem_req <= 1'b0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        if (jump) pr_q <= jump_target;
                        state_q <= ST_WBACK;
                    end
                end
                ST_WBACK: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else begin
                        mem_req <= 1'b1;
                        state_q <= ST_IFET1;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comet_ii_fetch_sequencer.sv
// Scoreboard bench for comet_ii_fetch_sequencer (default build, trap feature disabled).
module tb_comet_ii_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_addr_sel = 1'b0;
    logic [15:0] start_addr = 16'h0000;
    logic        stop = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic        exec_done = 1'b0;
    logic        jump = 1'b0;
    logic [15:0] jump_target = 16'h0000;
    logic [2:0]  state;
    logic [7:0]  op_code;
    logic [7:0]  regs;
    logic [15:0] adr;
    logic        adr_en;
    logic [15:0] pr;
    logic        illegal;

    always #5 clk = ~clk;

    comet_ii_fetch_sequencer #(.RESET_PR(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_addr_sel (start_addr_sel),
        .start_addr     (start_addr),
        .stop           (stop),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .exec_done      (exec_done),
        .jump           (jump),
        .jump_target    (jump_target),
        .state          (state),
        .op_code        (op_code),
        .regs           (regs),
        .adr            (adr),
        .adr_en         (adr_en),
        .pr             (pr),
        .illegal        (illegal)
    );

    typedef struct { logic [15:0] addr; logic [15:0] data; int wt; } fetch_t;
    typedef struct { logic [7:0] op; logic [7:0] rg; logic [15:0] adr; logic adr_en; logic [15:0] pr; int gap; } exp_t;
    typedef struct { int dly; logic jmp; logic [15:0] tgt; logic last; } dec_t;

    fetch_t fq[$];
    exp_t   eq[$];
    dec_t   dq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] two_ops [25] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31,
                                 8'h32, 8'h40, 8'h41, 8'h50, 8'h51, 8'h52, 8'h53, 8'h61, 8'h62,
                                 8'h63, 8'h64, 8'h65, 8'h66, 8'h70, 8'h80, 8'hF0};
    logic [7:0] one_ops [13] = '{8'h00, 8'h14, 8'h24, 8'h25, 8'h26, 8'h27, 8'h34, 8'h35, 8'h36,
                                 8'h44, 8'h45, 8'h71, 8'h81};
    logic [7:0] bad_ops [6]  = '{8'h99, 8'h01, 8'hFF, 8'h13, 8'h90, 8'hA5};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic bit is_two(input logic [7:0] op);
        foreach (two_ops[i]) if (two_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: walks the program address by address and records what must be seen.
    logic [15:0] m_pc;
    int          m_prev_exec;
    bit          m_first;

    task automatic push_instr(input logic [15:0] w1, input logic [15:0] w2, input int wt1,
                              input int wt2, input int dly, input logic jmp,
                              input logic [15:0] tgt, input logic last);
        exp_t e;
        int   fcyc;
        bit   two;
        two = is_two(w1[15:8]);
        fq.push_back('{m_pc, w1, wt1});
        fcyc = wt1 + 1;
        m_pc = m_pc + 16'd1;
        if (two) begin
            fq.push_back('{m_pc, w2, wt2});
            fcyc += wt2 + 1;
            m_pc = m_pc + 16'd1;
        end
        e.op     = w1[15:8];
        e.rg     = w1[7:0];
        e.adr    = two ? w2 : 16'h0000;
        e.adr_en = two;
        e.pr     = m_pc;
        e.gap    = m_first ? -1 : m_prev_exec + 1 + fcyc;
        eq.push_back(e);
        dq.push_back('{dly, jmp, tgt, last});
        m_prev_exec = dly + 1;
        m_first     = 1'b0;
        if (jmp) m_pc = tgt;
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    endfunction

    task automatic gen_run(input logic [15:0] pc0, input int n, input int pat);
        logic [7:0] op;
        int r;
        m_pc = pc0;
        m_first = 1'b1;
        m_prev_exec = 0;
        case (pat)
            1: push_instr(16'h1412, 16'h0000, 0, 0, 0, 1'b0, 16'h0000, 1'b0);
            2: push_instr(16'h1010, 16'h8000, 3, 3, 1, 1'b0, 16'h0000, 1'b0);
            3: push_instr(16'h1000, 16'h1234, rand_wait(), rand_wait(), 0, 1'b0, 16'h0000, 1'b0);
            4: begin
                push_instr(16'h6400, 16'h0200, 0, 0, 0, 1'b1, 16'h0200, 1'b0);
                push_instr(16'h6400, 16'h0300, 0, 1, 2, 1'b1, 16'h0300, 1'b0);
            end
            default: ;
        endcase
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)     op = bad_ops[$urandom_range(0, 5)];
            else if (r < 6) op = two_ops[$urandom_range(0, 24)];
            else            op = one_ops[$urandom_range(0, 12)];
            push_instr({op, 8'($urandom)}, 16'($urandom), rand_wait(), rand_wait(),
                       $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 16'($urandom),
                       (k == n - 1));
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: serves queued fetches with the chosen wait, checks the request address.
    logic        auto_mem = 1'b1;
    logic        man_ack = 1'b0;
    logic [15:0] man_data = 16'h0000;
    int          m_cnt = -1;
    fetch_t      cur_f;

    always @(negedge clk) begin
        if (!auto_mem) begin
            mem_ack   = man_ack;
            mem_rdata = man_data;
            m_cnt     = -1;
        end else if (!mem_req) begin
            m_cnt     = -1;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
        end else begin
            if (m_cnt < 0) begin
                if (fq.size() == 0) begin
                    fail("fetch_unexpected");
                    cur_f = '{mem_addr, 16'h0000, 0};
                end else begin
                    cur_f = fq.pop_front();
                end
                m_cnt = cur_f.wt;
            end
            check("mem_addr", 32'(mem_addr), 32'(cur_f.addr));
            if (m_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = cur_f.data;
                m_cnt     = -1;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                m_cnt--;
            end
        end
    end

    // Datapath responder: finishes EXEC after the chosen delay; jump is noise until done.
    logic x_in_exec = 1'b0;
    int   x_cnt = 0;
    dec_t cur_d;

    always @(negedge clk) begin
        if (state == 3'd4) begin
            if (!x_in_exec) begin
                x_in_exec = 1'b1;
                if (dq.size() == 0) begin
                    fail("exec_decision_missing");
                    cur_d = '{0, 1'b0, 16'h0000, 1'b1};
                end else begin
                    cur_d = dq.pop_front();
                end
                x_cnt = cur_d.dly;
            end
            if (x_cnt == 0) begin
                exec_done   = 1'b1;
                jump        = cur_d.jmp;
                jump_target = cur_d.tgt;
                if (cur_d.last) stop = 1'b1;
                x_cnt = -1;
            end else begin
                exec_done   = 1'b0;
                jump        = 1'b1;
                jump_target = 16'($urandom);
                if (x_cnt > 0) x_cnt--;
            end
        end else begin
            x_in_exec   = 1'b0;
            exec_done   = 1'b0;
            jump        = 1'($urandom);
            jump_target = 16'($urandom);
            if (state == 3'd0) stop = 1'b0;
        end
    end

    // Monitor: on every EXEC entry pop the expected instruction and compare.
    logic mon_in_exec = 1'b0;
    int   last_entry = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (state == 3'd4 && !mon_in_exec) begin
            mon_in_exec = 1'b1;
            if (eq.size() == 0) begin
                fail("exec_unexpected");
            end else begin
                mon_e = eq.pop_front();
                check("op_code", 32'(op_code), 32'(mon_e.op));
                check("regs", 32'(regs), 32'(mon_e.rg));
                check("adr", 32'(adr), 32'(mon_e.adr));
                check("adr_en", 32'(adr_en), 32'(mon_e.adr_en));
                check("pr", 32'(pr), 32'(mon_e.pr));
                check("illegal", 32'(illegal), 32'd0);
                if (mon_e.gap >= 0) check("exec_gap", 32'(cyc - last_entry), 32'(mon_e.gap));
            end
            last_entry = cyc;
        end else if (state != 3'd4) begin
            mon_in_exec = 1'b0;
        end
    end

    task automatic finish_now();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "run aborted");
    endtask

    task automatic run_one(input logic sel, input logic [15:0] addr, input int n, input int pat);
        int t;
        gen_run(sel ? addr : 16'h0000, n, pat);
        @(negedge clk);
        start_addr_sel = sel;
        start_addr     = addr;
        start          = 1'b1;
        t = 0;
        while (!stop && t < 5000) begin
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        if (t >= 5000) begin
            fail("run_timeout");
            finish_now();
        end
        t = 0;
        while (state != 3'd0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("idle_after_stop", 32'(state), 32'd0);
        repeat (2) @(negedge clk);
        check("idle_hold", 32'(state), 32'd0);
        check("idle_mem_req", 32'(mem_req), 32'd0);
        check("fetches_left", 32'(fq.size()), 32'd0);
        check("execs_left", 32'(eq.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pr", 32'(pr), 32'd0);
        check("rst_op_code", 32'(op_code), 32'd0);
        check("rst_regs", 32'(regs), 32'd0);
        check("rst_adr", 32'(adr), 32'd0);
        check("rst_adr_en", 32'(adr_en), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        run_one(1'b1, 16'h0100, 4, 1);
        run_one(1'b1, 16'h2345, 6, 2);
        run_one(1'b1, 16'hFFFF, 5, 3);
        run_one(1'b0, 16'h5A5A, 8, 0);
        run_one(1'b1, 16'h1000, 6, 4);
        for (int i = 0; i < 5; i++)
            run_one(1'($urandom), 16'($urandom), $urandom_range(5, 20), 0);

        // Reset mid-IFET2 with an ack in the same cycle.
        auto_mem = 1'b0;
        man_ack  = 1'b0;
        @(negedge clk);
        start_addr_sel = 1'b1;
        start_addr     = 16'h0200;
        start          = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("dir_init", 32'(state), 32'd1);
        @(posedge clk);
        #1;
        check("dir_ifet1", 32'(state), 32'd2);
        check("dir_req1", 32'(mem_req), 32'd1);
        check("dir_addr1", 32'(mem_addr), 32'h0200);
        man_ack  = 1'b1;
        man_data = 16'h1010;
        @(posedge clk);
        #1;
        check("dir_ifet2", 32'(state), 32'd3);
        check("dir_addr2", 32'(mem_addr), 32'h0201);
        check("dir_op", 32'(op_code), 32'h10);
        man_data = 16'h8000;
        rst      = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        man_ack = 1'b0;
        check("rst_ifet2_state", 32'(state), 32'd0);
        check("rst_ifet2_req", 32'(mem_req), 32'd0);
        check("rst_ifet2_adr", 32'(adr), 32'd0);
        check("rst_ifet2_adr_en", 32'(adr_en), 32'd0);
        check("rst_ifet2_pr", 32'(pr), 32'd0);
        repeat (2) @(negedge clk);
        check("rst_ifet2_idle", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/comet_ii_fetch_sequencer.md
# comet_ii_fetch_sequencer

Instruction fetch and CPU state sequencer for the COMET II core; sits directly upstream of `Comet_II_instrument_decoder`. It owns the program register (PR) and fetches one- and two-word instructions over a simple memory request/acknowledge port. It drives the decoder's `state`, `op_code`, `regs` and `adr_en` inputs, plus the latched address word. It advances through IDLE/INIT/IFET1/IFET2/EXEC/WBACK under memory-acknowledge and datapath-done handshakes.

## Interface
Parameters:
- `RESET_PR`, 16'h0000, PR value loaded in INIT when `start_addr_sel`=0

Ports (clock and reset first):
- `clk`  in  1  core clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  leave IDLE (level, sampled in IDLE only)
- `start_addr_sel`  in  1  1: INIT loads `start_addr`; 0: loads `RESET_PR`
- `start_addr`  in  16  program entry address
- `stop`  in  1  return to IDLE after current WBACK
- `mem_req`  out  1  fetch request, held until acknowledged
- `mem_addr`  out  16  fetch address (= PR while `mem_req`)
- `mem_rdata`  in  16  fetch data, valid with `mem_ack`
- `mem_ack`  in  1  fetch accepted and data valid this cycle
- `exec_done`  in  1  datapath finished EXEC work
- `jump`  in  1  decoder jump strobe (qualified by `exec_done`)
- `jump_target`  in  16  effective address to load into PR
- `state`  out  3  sequencer state to decoder
- `op_code`  out  8  latched word1[15:8]
- `regs`  out  8  latched word1[7:0]
- `adr`  out  16  latched word2 (0 for one-word instructions)
- `adr_en`  out  1  1 when current instruction has an address word
- `pr`  out  16  current program register
- `illegal`  out  1  sticky illegal-opcode flag (see Configuration)

## Operation
- State encoding: IDLE 000, INIT 001, IFET1 010, IFET2 011, EXEC 100, WBACK 101; 110/111 → IDLE next cycle.
- IDLE: `mem_req`=0. `start`=1 → INIT.
- INIT (1 cycle): PR ← `start_addr` or `RESET_PR`; `adr_en`←0; `illegal`←0 → IFET1.
- IFET1: `mem_req`=1, `mem_addr`=PR. On `mem_ack`: `op_code`/`regs` ← `mem_rdata`, PR ← PR+1. Two-word opcode → IFET2; otherwise `adr`←0, `adr_en`←0 → EXEC.
- Two-word opcodes: 10,11,12; 20–23; 30–32; 40,41; 50–53; 61–66; 70; 80; F0. One-word: 00, 14, 24–27, 34–36, 44, 45, 71, 81.
- IFET2: `mem_req`=1, `mem_addr`=PR. On `mem_ack`: `adr` ← `mem_rdata`, `adr_en`←1, PR ← PR+1 → EXEC.
- EXEC: hold until `exec_done`. If `exec_done`&`jump`: PR ← `jump_target`. Then → WBACK.
- WBACK (1 cycle): `stop`=1 → IDLE, else → IFET1.
- PR arithmetic is modulo 2^16; FFFF+1 = 0000.
- `op_code`, `regs`, `adr`, `adr_en` hold their values from capture until the next capture.

## Timing
- Reset values: `state`=IDLE, `pr`=0, `op_code`=0, `regs`=0, `adr`=0, `adr_en`=0, `mem_req`=0, `mem_addr`=0, `illegal`=0.
- `rst` in any state, including mid-fetch with `mem_req` high, reaches IDLE next edge. An ack arriving that cycle is discarded.
- `mem_req` and `mem_addr` are registered. `mem_ack` is sampled only while `mem_req`=1; an ack with `mem_req`=0 is ignored.
- Zero-wait memory: `mem_ack` in the first IFET1 cycle gives IFET1→EXEC in 1 cycle (one-word) or IFET1→IFET2→EXEC in 2 cycles.
- Minimum loop: one-word 3 cycles (IFET1, EXEC with `exec_done`, WBACK); two-word 4 cycles.
- `jump` without `exec_done` has no effect. `stop` outside WBACK is not latched.
- `start` outside IDLE is ignored.

## Configuration
- `COMET_II_ILLEGAL_TRAP_EN` defined: an IFET1 capture of an opcode not in either list pulses no EXEC. The opcode is still captured, `illegal`←1 (sticky until INIT), and state → IDLE.
- Not defined: unknown opcodes are treated as one-word and go to EXEC (the decoder maps them to ALU_NOP); `illegal` is tied 0.

## Structure
- Shared package `comet_ii_pkg`: state encodings (IDLE…WBACK), opcode constants, and the word-width constant (16).
- Sub-module `comet_ii_op_length`: combinational opcode → {`two_word`, `legal`} classifier, reused by the decoder's future checks.
- Sequencer: FSM plus PR/latch registers.

## Test plan
- Reset, then `start` with `start_addr_sel`=1, `start_addr`=0100, zero-wait memory returning 1412 (LD r1,r2) → INIT, IFET1, EXEC; `op_code`=14, `regs`=12, `adr_en`=0, `pr`=0101.
- Word1 1010, word2 8000 with `mem_ack` delayed 3 cycles each → `mem_addr` stable and `mem_req` held high during each wait; `adr`=8000, `adr_en`=1, `pr`=start+2.
- JUMP 6400/0200 with `exec_done`&`jump`, `jump_target`=0200 → after WBACK, IFET1 `mem_addr`=0200. Repeat with `jump`=1, `exec_done`=0 for 2 cycles → no PR change until done.
- PR=FFFF fetching two-word 1000/1234 → second fetch from 0000, final `pr`=0001.
- `rst` asserted in IFET2 with `mem_ack` in the same cycle → IDLE, `mem_req`=0, `adr` unchanged at reset value 0; `stop`=1 in WBACK → IDLE, `start` ignored until then.
- With `COMET_II_ILLEGAL_TRAP_EN`: fetch 9900 → `illegal`=1, state IDLE, no EXEC cycle. Without the macro: EXEC entered, `adr_en`=0, `illegal`=0.
